// File: rtl/tl_ram_responder.sv
// tl_ram_responder
//   Single-beat TileLink-UL slave backed by a small 64-bit-wide RAM.
//   Accepts PutFullData (0), PutPartialData (1) and Get (4) inside a
//   256-byte window at BASE_ADDR, and answers each with one D beat one
//   cycle later. Requests outside the window or otherwise malformed are
//   answered with denied=1 and leave the storage untouched.
//
// Ports
//   clock                      sole clock, rising edge
//   reset                      asynchronous, active-low
//   auto_in_a_*                A channel (request) from the master
//   auto_in_d_*                D channel (response) to the master
//   dbg_state                  response register state (0 = EMPTY, 1 = FULL)
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high. valid never depends on ready. a_ready depends on d_ready so a
// new request can be accepted in the same cycle the held response drains.
module tl_ram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          DEPTH     = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [3:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [3:0]  auto_in_d_bits_source,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt,
  output logic        dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [63:0] mem [DEPTH];

  logic             a_fire;
  logic             d_fire;
  logic [4:0]       word_sel;
  logic [IDX_W-1:0] word_idx;
  logic             in_window;
  logic             idx_ok;
  logic             aligned;
  logic             opcode_ok;
  logic             legal;
  logic             is_get;
  logic             wr_en;

  logic [2:0]  rsp_opcode;
  logic        rsp_denied;
  logic [63:0] rsp_data;
  logic        rsp_corrupt;

  logic unused_param;
  assign unused_param = ^auto_in_a_bits_param;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  assign auto_in_d_valid = (state_q == FULL);
  assign dbg_state       = (state_q == FULL);
  assign auto_in_a_ready = reset & (~auto_in_d_valid | auto_in_d_ready);
  assign a_fire          = auto_in_a_valid & auto_in_a_ready;
  assign d_fire          = auto_in_d_valid & auto_in_d_ready;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  assign word_sel  = auto_in_a_bits_address[7:3];
  assign word_idx  = word_sel[IDX_W-1:0];
  assign in_window = (auto_in_a_bits_address[31:8] == BASE_ADDR[31:8]);
  assign idx_ok    = ({27'd0, word_sel} < 32'(DEPTH));
  assign is_get    = (auto_in_a_bits_opcode == OP_GET);
  assign opcode_ok = (auto_in_a_bits_opcode == OP_PUT_FULL) |
                     (auto_in_a_bits_opcode == OP_PUT_PARTIAL) | is_get;

  // Sizes above 3 exceed the 8-byte beat and fall through as misaligned.
  always_comb begin
    aligned = 1'b0;
    case (auto_in_a_bits_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (auto_in_a_bits_address[0] == 1'b0);
      3'd2:    aligned = (auto_in_a_bits_address[1:0] == 2'b00);
      3'd3:    aligned = (auto_in_a_bits_address[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
  end

  assign legal = in_window & idx_ok & aligned & opcode_ok;

  // Poisoned write data is acknowledged but never committed.
  assign wr_en = a_fire & legal & ~is_get & ~auto_in_a_bits_corrupt;

  // ---------------------------------------------------------------------
  // Response field selection
  // ---------------------------------------------------------------------
  always_comb begin
    rsp_opcode  = OP_ACK;
    rsp_denied  = 1'b0;
    rsp_data    = '0;
    rsp_corrupt = 1'b0;
    if (!legal) begin
      rsp_denied = 1'b1;
      if (is_get) begin
        rsp_opcode  = OP_ACK_DATA;
        rsp_corrupt = 1'b1;
      end
    end else if (is_get) begin
      rsp_opcode = OP_ACK_DATA;
      rsp_data   = mem[word_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Response register state machine
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (a_fire) state_d = FULL;
      FULL:    if (d_fire && !a_fire) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Fields load only on A fire, so they hold while the beat is stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_in_d_bits_opcode  <= '0;
      auto_in_d_bits_size    <= '0;
      auto_in_d_bits_source  <= '0;
      auto_in_d_bits_denied  <= 1'b0;
      auto_in_d_bits_data    <= '0;
      auto_in_d_bits_corrupt <= 1'b0;
    end else if (a_fire) begin
      auto_in_d_bits_opcode  <= rsp_opcode;
      auto_in_d_bits_size    <= auto_in_a_bits_size;
      auto_in_d_bits_source  <= auto_in_a_bits_source;
      auto_in_d_bits_denied  <= rsp_denied;
      auto_in_d_bits_data    <= rsp_data;
      auto_in_d_bits_corrupt <= rsp_corrupt;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: byte-lane writes committed on the fire edge, so a Get in the
  // following cycle already sees the new contents.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (auto_in_a_bits_mask[b]) begin
          mem[word_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/tl_ram_responder.md
TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h6000_0000, meaning 256-byte-aligned base of the responder window.
REQ-002 Parameter DEPTH, default 32, meaning number of 64-bit storage words; window size is DEPTH*8 bytes.
REQ-003 Port clock  input  1  meaning sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  meaning reset, asynchronous, active-low.
REQ-005 Port auto_in_a_ready  output  1  meaning A-channel accept.
REQ-006 Port auto_in_a_valid  input  1  meaning A-channel request valid.
REQ-007 Ports auto_in_a_bits_opcode/param/size  input  3/3/3  meaning TileLink-UL A fields; param ignored.
REQ-008 Ports auto_in_a_bits_source/address  input  4/32  meaning requester ID, byte address.
REQ-009 Ports auto_in_a_bits_mask/data/corrupt  input  8/64/1  meaning byte lanes, write data, data-poison flag.
REQ-010 Port auto_in_d_ready  input  1  meaning D-channel consumer accept.
REQ-011 Port auto_in_d_valid  output  1  meaning D-channel response valid.
REQ-012 Ports auto_in_d_bits_opcode/size/source  output  3/3/4  meaning response type, echoed size, echoed source.
REQ-013 Ports auto_in_d_bits_denied/data/corrupt  output  1/64/1  meaning error flag, read data, data-poison flag.

Function
REQ-014 Single-beat TileLink-UL responder; one-entry response register (state EMPTY when d_valid=0, FULL when d_valid=1).
REQ-015 a_ready = reset deasserted AND (d_valid=0 OR d_ready=1); A fires when a_valid AND a_ready.
REQ-016 On A fire, response register loads on the same edge; d_valid=1 the next cycle (latency 1).
REQ-017 On D fire (d_valid AND d_ready) with no A fire, d_valid clears; with simultaneous A fire, register reloads and d_valid stays 1 (full throughput, one beat per cycle).
REQ-018 Response fields hold stable while d_valid=1 and d_ready=0.
REQ-019 Request legal iff address[31:8]==BASE_ADDR[31:8], word index address[7:3] < DEPTH, size <= 3, address aligned to 2^size, opcode in {0 PutFull, 1 PutPartial, 4 Get}.
REQ-020 Legal Get: d_opcode=1 (AccessAckData), d_data = storage word at index as of the fire edge, denied=0, corrupt=0.
REQ-021 Legal Put: d_opcode=0 (AccessAck), denied=0, d_data=0; byte i of word written iff mask[i]=1, committed on the fire edge.
REQ-022 Put with a_corrupt=1: storage not written; response AccessAck, denied=0.
REQ-023 Illegal request: storage untouched, denied=1; d_opcode=1 with corrupt=1, data=0 if opcode was Get, else d_opcode=0, corrupt=0.
REQ-024 d_size and d_source always equal a_size and a_source of the request being answered.
REQ-025 Put to index N followed by Get to index N in the next cycle returns the new data (no hazard).

Reset
REQ-026 While reset low: d_valid=0, a_ready=0, d_opcode/size/source/denied/data/corrupt=0, all storage words=0.
REQ-027 Reset asserted mid-operation discards any pending response; no D beat completes after reset deassertion for a request accepted before it.
REQ-028 First cycle after reset deassertion: a_ready=1.

Verification
REQ-029 PutFull size 3, addr 0x6000_0008, mask 0xFF, data 0x1122334455667788, d_ready=1 -> next cycle AccessAck, denied=0; following Get same address -> AccessAckData data 0x1122334455667788.
REQ-030 PutPartial addr 0x6000_0008, mask 0x0F, data 0xAAAAAAAA_BBBBBBBB over prior value -> Get returns 0x11223344BBBBBBBB.
REQ-031 Get addr 0x7000_0000 source 5 -> d_opcode=1, denied=1, corrupt=1, data=0, source=5; Get size 3 at 0x6000_0004 -> denied=1.
REQ-032 Hold d_ready=0 for 4 cycles after a Get -> a_ready=0, d fields stable; raise d_ready with new a_valid -> back-to-back beats, one per cycle.
REQ-033 Put with a_corrupt=1 to 0x6000_0010, data 0xFFFF... -> AccessAck denied=0; Get returns 0.
REQ-034 Assert reset while d_valid=1 -> d_valid=0 immediately (asynchronous); after release, Get any address in window returns 0.
